// File: rtl/sdram_auto_refresh.sv
// Periodic SDRAM auto-refresh: interval timer, arbiter handshake and PRECHARGE ALL + 2x AUTO REFRESH sequencer.
// Optional sticky missed-refresh flag aref_ovf is built only when SDRAM_AREF_OVF_EN is defined.
module sdram_auto_refresh #(
  parameter int CLK_FREQ_MHZ = 50,
  parameter int TREF_NS      = 7800,
  parameter int TRP_CYC      = 2,
  parameter int TRC_CYC      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init_done,
  input  logic        aref_en,
  output logic        aref_req,
  output logic        aref_done,
  output logic [3:0]  sdram_cmds,
  output logic [12:0] sdram_addrs,
  output logic        aref_ovf
);

  localparam int              INTERVAL = TREF_NS * CLK_FREQ_MHZ / 1000;
  localparam int              CNT_W    = $clog2(INTERVAL);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INTERVAL - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [3:0]      CMD_NOP  = 4'b0111;
  localparam logic [3:0]      CMD_PRE  = 4'b0010;
  localparam logic [3:0]      CMD_AREF = 4'b0001;
  localparam logic [12:0]     ADDR_ALL = 13'h0400;
  localparam logic [7:0]      TRP_LOAD = 8'(TRP_CYC - 1);
  localparam logic [7:0]      TRC_LOAD = 8'(TRC_CYC - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PCHG      = 3'd1,
    TRP_WAIT  = 3'd2,
    AREF1     = 3'd3,
    TRC_WAIT1 = 3'd4,
    AREF2     = 3'd5,
    TRC_WAIT2 = 3'd6,
    DONE      = 3'd7
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q, req_d;
  logic [3:0]       cmd_q, cmd_d;
  logic [12:0]      addr_q, addr_d;
  logic             done_q, done_d;
  logic             grant_s;

  // Free-running interval timer and pending-request flag; a wrap while pending keeps the single request.
  always_comb begin
    grant_s = aref_en & req_q & (state_q == IDLE);
    cnt_d   = {CNT_W{1'b0}};
    req_d   = 1'b0;
    if (!init_done) begin
      cnt_d = {CNT_W{1'b0}};
      req_d = 1'b0;
    end else begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = {CNT_W{1'b0}};
        req_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
        req_d = grant_s ? 1'b0 : req_q;
      end
    end
  end

  // Sequencer next state; commands are decoded from the next state so they register alongside it.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      IDLE: begin
        if (grant_s) state_d = PCHG;
        else         state_d = IDLE;
      end
      PCHG: begin
        state_d = TRP_WAIT;
        wait_d  = TRP_LOAD;
      end
      TRP_WAIT: begin
        if (wait_q == 8'd0) state_d = AREF1;
        else                wait_d  = wait_q - 8'd1;
      end
      AREF1: begin
        state_d = TRC_WAIT1;
        wait_d  = TRC_LOAD;
      end
      TRC_WAIT1: begin
        if (wait_q == 8'd0) state_d = AREF2;
        else                wait_d  = wait_q - 8'd1;
      end
      AREF2: begin
        state_d = TRC_WAIT2;
        wait_d  = TRC_LOAD;
      end
      TRC_WAIT2: begin
        if (wait_q == 8'd0) state_d = DONE;
        else                wait_d  = wait_q - 8'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    case (state_d)
      PCHG: begin
        cmd_d  = CMD_PRE;
        addr_d = ADDR_ALL;
      end
      AREF1, AREF2: begin
        cmd_d  = CMD_AREF;
        addr_d = 13'h0000;
      end
      default: begin
        cmd_d  = CMD_NOP;
        addr_d = 13'h0000;
      end
    endcase
    done_d = (state_d == DONE);
  end

  // State, timer and registered command outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wait_q  <= 8'd0;
      cnt_q   <= {CNT_W{1'b0}};
      req_q   <= 1'b0;
      cmd_q   <= CMD_NOP;
      addr_q  <= 13'h0000;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
    end
  end

  assign aref_req    = req_q;
  assign aref_done   = done_q;
  assign sdram_cmds  = cmd_q;
  assign sdram_addrs = addr_q;

`ifdef SDRAM_AREF_OVF_EN
  logic aref_ovf_q, aref_ovf_d;

  // A whole further interval elapsed with the previous request still unserviced.
  always_comb begin
    if ((cnt_q == CNT_LAST) && req_q) aref_ovf_d = 1'b1;
    else                              aref_ovf_d = aref_ovf_q;
  end

  // Sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) aref_ovf_q <= 1'b0;
    else     aref_ovf_q <= aref_ovf_d;
  end

  assign aref_ovf = aref_ovf_q;
`else
  assign aref_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_auto_refresh.sv
// Randomised bench for sdram_auto_refresh against a cycle-level behavioural model.
module tb_sdram_auto_refresh;

  localparam int INTERVAL = 7800 * 50 / 1000;
  localparam int TRP      = 2;
  localparam int TRC      = 4;

  typedef struct {
    logic [3:0]  cmd;
    logic [12:0] addr;
    logic        done;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_i, init_i, en_i;
  logic        aref_req, aref_done, aref_ovf;
  logic [3:0]  sdram_cmds;
  logic [12:0] sdram_addrs;

  int   n_cmp = 0;
  int   n_err = 0;
  int   g_edges = 0;
  int   m_cnt = 0;
  bit   m_req = 1'b0;
  bit   m_ovf = 1'b0;
  exp_t m_q[$];
  exp_t e_cur;

  sdram_auto_refresh dut (
    .clk        (clk),
    .rst        (rst_i),
    .init_done  (init_i),
    .aref_en    (en_i),
    .aref_req   (aref_req),
    .aref_done  (aref_done),
    .sdram_cmds (sdram_cmds),
    .sdram_addrs(sdram_addrs),
    .aref_ovf   (aref_ovf)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [3:0] c, input logic [12:0] a, input logic d);
    exp_t e;
    e.cmd = c; e.addr = a; e.done = d;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h at edge %0d", tag, obs, exp, g_edges);
    end
  endtask

  // Expected bus activity after a grant, written out from the command sequence.
  task automatic push_seq();
    m_q.push_back(mk(4'b0010, 13'h0400, 1'b0));
    for (int i = 0; i < TRP; i++) m_q.push_back(mk(4'b0111, 13'h0000, 1'b0));
    m_q.push_back(mk(4'b0001, 13'h0000, 1'b0));
    for (int i = 0; i < TRC; i++) m_q.push_back(mk(4'b0111, 13'h0000, 1'b0));
    m_q.push_back(mk(4'b0001, 13'h0000, 1'b0));
    for (int i = 0; i < TRC; i++) m_q.push_back(mk(4'b0111, 13'h0000, 1'b0));
    m_q.push_back(mk(4'b0111, 13'h0000, 1'b1));
    m_q.push_back(mk(4'b0111, 13'h0000, 1'b0));
  endtask

  task automatic tick();
    bit grant;
    logic exp_ovf;
    grant = !rst_i && en_i && m_req && (m_q.size() == 0);
    if (rst_i) begin
      m_cnt = 0; m_req = 1'b0; m_ovf = 1'b0; m_q.delete();
      e_cur = mk(4'b0111, 13'h0000, 1'b0);
    end else begin
      if (m_cnt == INTERVAL - 1 && m_req) m_ovf = 1'b1;
      if (!init_i)                     m_req = 1'b0;
      else if (m_cnt == INTERVAL - 1)  m_req = 1'b1;
      else if (grant)                  m_req = 1'b0;
      m_cnt = init_i ? (m_cnt + 1) % INTERVAL : 0;
      if (grant) push_seq();
      if (m_q.size() > 0) e_cur = m_q.pop_front();
      else                e_cur = mk(4'b0111, 13'h0000, 1'b0);
    end
`ifdef SDRAM_AREF_OVF_EN
    exp_ovf = m_ovf;
`else
    exp_ovf = 1'b0;
`endif
    @(posedge clk);
    #1;
    g_edges++;
    chk("cmds", 32'(sdram_cmds), 32'(e_cur.cmd));
    chk("addrs", 32'(sdram_addrs), 32'(e_cur.addr));
    chk("aref_done", 32'(aref_done), 32'(e_cur.done));
    chk("aref_req", 32'(aref_req), 32'(m_req));
    chk("aref_ovf", 32'(aref_ovf), 32'(exp_ovf));
  endtask

  task automatic wait_req(input int budget, output int n);
    n = 0;
    while (!aref_req && n < budget) begin
      en_i = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    en_i = 1'b0;
    if (!aref_req) chk("req_timeout", 32'(aref_req), 32'd1);
  endtask

  initial begin
    int start;
    int n;
    rst_i = 1'b1; init_i = 1'b0; en_i = 1'b0;
    repeat (3) tick();
    rst_i = 1'b0;

    // Not initialised: no request, stray grants ignored.
    for (int i = 0; i < 2000; i++) begin
      en_i = 1'($urandom_range(0, 1));
      tick();
    end

    // First request after one interval, serviced by a grant three cycles later.
    init_i = 1'b1;
    start  = g_edges;
    wait_req(INTERVAL + 50, n);
    chk("first_req_edge", 32'(g_edges - start), 32'(INTERVAL));
    en_i = 1'b0;
    repeat (2) tick();
    en_i = 1'b1; tick();
    en_i = 1'b0;
    wait_req(INTERVAL + 50, n);
    chk("second_req_edge", 32'(g_edges - start), 32'(2 * INTERVAL));

    // Starved request across two wraps.
    en_i = 1'b0;
    repeat (800) tick();

    // Grant, then reset while AUTO REFRESH #1 is on the bus.
    en_i = 1'b1; tick();
    en_i = 1'b0;
    repeat (3) tick();
    chk("aref1_before_rst", 32'(sdram_cmds), 32'(4'b0001));
    rst_i = 1'b1; tick();
    rst_i = 1'b0;
    start = g_edges;
    wait_req(INTERVAL + 50, n);
    chk("req_after_rst_edge", 32'(g_edges - start), 32'(INTERVAL));

    // init_done drops mid-sequence: sequence still completes, no new request.
    en_i = 1'b1; tick();
    en_i = 1'b0; tick();
    init_i = 1'b0;
    repeat (20) tick();
    init_i = 1'b1;

    // Random mix of grants, init drops and occasional resets.
    for (int i = 0; i < 6000; i++) begin
      en_i  = ($urandom_range(0, 9) == 0);
      rst_i = ($urandom_range(0, 1999) == 0);
      if ($urandom_range(0, 399) == 0) init_i = ~init_i;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
